// File: rtl/fb_wr_sched_if.sv
// Framebuffer write scheduler bus: host pixel stream, fill command/status
// and the registered framebuffer write port.
// master = requester side (host/bus logic), slave = the scheduler.
interface fb_wr_sched_if #(
  parameter int unsigned AW = 17,
  parameter int unsigned DW = 24
) ();

  logic          host_valid;
  logic          host_ready;
  logic [10:0]   host_x;
  logic [10:0]   host_y;
  logic [DW-1:0] host_color;

  logic          fill_start;
  logic [10:0]   fill_x0;
  logic [10:0]   fill_y0;
  logic [10:0]   fill_w;
  logic [10:0]   fill_h;
  logic [DW-1:0] fill_color;
  logic          fill_busy;
  logic          fill_done;

  logic          fb_ena;
  logic          fb_wea;
  logic [AW-1:0] fb_addra;
  logic [DW-1:0] fb_dina;

  modport master (
    output host_valid, host_x, host_y, host_color,
    output fill_start, fill_x0, fill_y0, fill_w, fill_h, fill_color,
    input  host_ready, fill_busy, fill_done,
    input  fb_ena, fb_wea, fb_addra, fb_dina
  );

  modport slave (
    input  host_valid, host_x, host_y, host_color,
    input  fill_start, fill_x0, fill_y0, fill_w, fill_h, fill_color,
    output host_ready, fill_busy, fill_done,
    output fb_ena, fb_wea, fb_addra, fb_dina
  );

endinterface

// File: rtl/fb_wr_sched.sv
// Framebuffer write-port scheduler: shares one registered write port between
// a host pixel stream and a rectangle fill engine, with clipping to the panel
// and round-robin arbitration on contention.
// Optional write/drop statistics counters: define FB_WR_STATS_EN.
module fb_wr_sched #(
  parameter int unsigned FB_W = 480,
  parameter int unsigned FB_H = 272,
  parameter int unsigned AW   = 17,
  parameter int unsigned DW   = 24
) (
  input  logic          sys_clk,
  input  logic          sys_rst,
  fb_wr_sched_if.slave  bus
`ifdef FB_WR_STATS_EN
  ,
  output logic [31:0]   stat_wr_cnt,
  output logic [15:0]   stat_drop_cnt
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_DONE} state_t;
  typedef enum logic {RR_HOST, RR_FILL} rr_t;

  state_t        state_q, state_d;
  rr_t           rr_q, rr_d;

  logic [10:0]   x0_q, x0_d, y0_q, y0_d, w_q, w_d, h_q, h_d;
  logic [DW-1:0] color_q, color_d;
  logic [10:0]   cx_q, cx_d, cy_q, cy_d;
  logic [10:0]   xlast_q, xlast_d, ylast_q, ylast_d;

  logic          ena_q, ena_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] din_q, din_d;

  logic [10:0]   x_rem, y_rem, w_eff, h_eff;
  logic          fill_gnt, host_gnt, host_rdy, host_in, host_drop;

  function automatic logic [AW-1:0] lin_addr(input logic [10:0] x, input logic [10:0] y);
    logic [31:0] a;
    a = 32'(y) * 32'(FB_W) + 32'(x);
    return a[AW-1:0];
  endfunction

  // Clipped fill extents from the latched rectangle (used in LOAD)
  always_comb begin
    x_rem = '0;
    y_rem = '0;
    if (x0_q < 11'(FB_W)) x_rem = 11'(FB_W) - x0_q;
    if (y0_q < 11'(FB_H)) y_rem = 11'(FB_H) - y0_q;
    w_eff = (w_q < x_rem) ? w_q : x_rem;
    h_eff = (h_q < y_rem) ? h_q : y_rem;
  end

  // Arbitration: fill competes only in RUN; on contention the side not granted last wins
  always_comb begin
    fill_gnt  = 1'b0;
    host_rdy  = 1'b0;
    host_gnt  = 1'b0;
    host_in   = 1'b0;
    host_drop = 1'b0;
    if (state_q == S_RUN)
      fill_gnt = ~bus.host_valid | (rr_q == RR_HOST);
    host_rdy  = ~fill_gnt & ~sys_rst;
    host_gnt  = bus.host_valid & host_rdy;
    host_in   = (bus.host_x < 11'(FB_W)) && (bus.host_y < 11'(FB_H));
    host_drop = host_gnt & ~host_in;
  end

  // Fill FSM next state, fill cursor and output-stage next values
  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    x0_d    = x0_q;
    y0_d    = y0_q;
    w_d     = w_q;
    h_d     = h_q;
    color_d = color_q;
    cx_d    = cx_q;
    cy_d    = cy_q;
    xlast_d = xlast_q;
    ylast_d = ylast_q;
    ena_d   = 1'b0;
    addr_d  = addr_q;
    din_d   = din_q;

    case (state_q)
      S_IDLE: begin
        if (bus.fill_start) begin
          x0_d    = bus.fill_x0;
          y0_d    = bus.fill_y0;
          w_d     = bus.fill_w;
          h_d     = bus.fill_h;
          color_d = bus.fill_color;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        cx_d    = x0_q;
        cy_d    = y0_q;
        xlast_d = x0_q + w_eff - 11'd1;
        ylast_d = y0_q + h_eff - 11'd1;
        state_d = (w_eff == '0 || h_eff == '0) ? S_DONE : S_RUN;
      end
      S_RUN: begin
        if (fill_gnt) begin
          if (cx_q == xlast_q) begin
            cx_d = x0_q;
            if (cy_q == ylast_q) state_d = S_DONE;
            else                 cy_d    = cy_q + 11'd1;
          end else begin
            cx_d = cx_q + 11'd1;
          end
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (fill_gnt) begin
      rr_d   = RR_FILL;
      ena_d  = 1'b1;
      addr_d = lin_addr(cx_q, cy_q);
      din_d  = color_q;
    end else if (host_gnt) begin
      rr_d = RR_HOST;
      if (host_in) begin
        ena_d  = 1'b1;
        addr_d = lin_addr(bus.host_x, bus.host_y);
        din_d  = bus.host_color;
      end
    end
  end

  // State, fill context and registered framebuffer port
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q <= S_IDLE;
      rr_q    <= RR_FILL;
      x0_q    <= '0;
      y0_q    <= '0;
      w_q     <= '0;
      h_q     <= '0;
      color_q <= '0;
      cx_q    <= '0;
      cy_q    <= '0;
      xlast_q <= '0;
      ylast_q <= '0;
      ena_q   <= 1'b0;
      addr_q  <= '0;
      din_q   <= '0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      x0_q    <= x0_d;
      y0_q    <= y0_d;
      w_q     <= w_d;
      h_q     <= h_d;
      color_q <= color_d;
      cx_q    <= cx_d;
      cy_q    <= cy_d;
      xlast_q <= xlast_d;
      ylast_q <= ylast_d;
      ena_q   <= ena_d;
      addr_q  <= addr_d;
      din_q   <= din_d;
    end
  end

  assign bus.host_ready = host_rdy;
  assign bus.fill_busy  = (state_q != S_IDLE);
  assign bus.fill_done  = (state_q == S_DONE);
  assign bus.fb_ena     = ena_q;
  assign bus.fb_wea     = ena_q;
  assign bus.fb_addra   = addr_q;
  assign bus.fb_dina    = din_q;

`ifdef FB_WR_STATS_EN
  logic [31:0] wr_cnt_q;
  logic [15:0] drop_cnt_q;

  // Saturating counters of issued writes and clipped host beats
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      wr_cnt_q   <= '0;
      drop_cnt_q <= '0;
    end else begin
      if (ena_d && (wr_cnt_q != '1))       wr_cnt_q   <= wr_cnt_q + 32'd1;
      if (host_drop && (drop_cnt_q != '1)) drop_cnt_q <= drop_cnt_q + 16'd1;
    end
  end

  assign stat_wr_cnt   = wr_cnt_q;
  assign stat_drop_cnt = drop_cnt_q;
`endif

endmodule

// File: tb/tb_fb_wr_sched.sv
// Self-checking bench for fb_wr_sched: scoreboard of expected framebuffer
// writes plus cycle-accurate checks of handshake and fill status timing.
module tb_fb_wr_sched;

  localparam int unsigned AW = 17;
  localparam int unsigned DW = 24;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fb_wr_sched_if #(.AW(AW), .DW(DW)) bus ();

`ifdef FB_WR_STATS_EN
  logic [31:0] stat_wr;
  logic [15:0] stat_drop;
`endif

  fb_wr_sched #(.FB_W(480), .FB_H(272), .AW(AW), .DW(DW)) dut (
    .sys_clk (clk),
    .sys_rst (rst),
    .bus     (bus)
`ifdef FB_WR_STATS_EN
    ,
    .stat_wr_cnt   (stat_wr),
    .stat_drop_cnt (stat_drop)
`endif
  );

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;
  wr_t sb[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
  endtask

  task automatic push(input int unsigned addr, input logic [DW-1:0] data);
    wr_t e;
    e.addr = AW'(addr);
    e.data = data;
    sb.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_fill(input int unsigned x0, input int unsigned y0,
                            input int unsigned w, input int unsigned h,
                            input logic [DW-1:0] color);
    bus.fill_x0    = 11'(x0);
    bus.fill_y0    = 11'(y0);
    bus.fill_w     = 11'(w);
    bus.fill_h     = 11'(h);
    bus.fill_color = color;
    bus.fill_start = 1'b1;
    tick();
    bus.fill_start = 1'b0;
  endtask

  // Every framebuffer write must match the oldest expected write
  always @(negedge clk) begin
    if (!rst && bus.fb_ena) begin
      check("sb_wea", 64'(bus.fb_wea), 64'd1);
      if (sb.size() == 0) begin
        check("sb_extra_write", 64'(sb.size()), 64'd1);
      end else begin
        wr_t e;
        e = sb.pop_front();
        check("sb_addr", 64'(bus.fb_addra), 64'(e.addr));
        check("sb_data", 64'(bus.fb_dina), 64'(e.data));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned hs;

    bus.host_valid = 1'b0;
    bus.host_x     = '0;
    bus.host_y     = '0;
    bus.host_color = '0;
    bus.fill_start = 1'b0;
    bus.fill_x0    = '0;
    bus.fill_y0    = '0;
    bus.fill_w     = '0;
    bus.fill_h     = '0;
    bus.fill_color = '0;

    // Reset state, with a host request pending to show ready is held low
    tick();
    bus.host_valid = 1'b1;
    #1;
    check("rst_ready", 64'(bus.host_ready), 64'd0);
    check("rst_ena",   64'(bus.fb_ena),     64'd0);
    check("rst_wea",   64'(bus.fb_wea),     64'd0);
    check("rst_addr",  64'(bus.fb_addra),   64'd0);
    check("rst_din",   64'(bus.fb_dina),    64'd0);
    check("rst_busy",  64'(bus.fill_busy),  64'd0);
    check("rst_done",  64'(bus.fill_done),  64'd0);
    bus.host_valid = 1'b0;
    tick();
    rst = 1'b0;
    tick();

    // T1: single host write
    bus.host_x     = 11'd10;
    bus.host_y     = 11'd2;
    bus.host_color = 24'hFF0000;
    bus.host_valid = 1'b1;
    push(970, 24'hFF0000);
    #1;
    check("t1_ready", 64'(bus.host_ready), 64'd1);
    tick();
    bus.host_valid = 1'b0;
    check("t1_ena",  64'(bus.fb_ena),   64'd1);
    check("t1_addr", 64'(bus.fb_addra), 64'd970);
    #1;
    check("t1_ready_after", 64'(bus.host_ready), 64'd1);
    tick();
    check("t1_ena_off", 64'(bus.fb_ena), 64'd0);

    // T2: 4x2 fill at origin, writes on consecutive cycles
    push(0, 24'h00FF00); push(1, 24'h00FF00); push(2, 24'h00FF00); push(3, 24'h00FF00);
    push(480, 24'h00FF00); push(481, 24'h00FF00); push(482, 24'h00FF00); push(483, 24'h00FF00);
    start_fill(0, 0, 4, 2, 24'h00FF00);
    check("t2_busy_load", 64'(bus.fill_busy), 64'd1);
    tick();
    check("t2_no_ena_yet", 64'(bus.fb_ena), 64'd0);
    for (int i = 0; i < 8; i++) begin
      tick();
      check("t2_ena", 64'(bus.fb_ena), 64'd1);
      check("t2_done", 64'(bus.fill_done), (i == 7) ? 64'd1 : 64'd0);
    end
    check("t2_last_addr", 64'(bus.fb_addra), 64'd483);
    tick();
    check("t2_busy_off", 64'(bus.fill_busy), 64'd0);
    check("t2_ena_off",  64'(bus.fb_ena),    64'd0);

    // T3: fill under continuous host load alternates host/fill, host first
    for (int i = 0; i < 8; i++) begin
      push(2405, 24'h0000FF);
      push((i / 4) * 480 + (i % 4), 24'h00FF00);
    end
    bus.host_x     = 11'd5;
    bus.host_y     = 11'd5;
    bus.host_color = 24'h0000FF;
    start_fill(0, 0, 4, 2, 24'h00FF00);
    tick();
    bus.host_valid = 1'b1;
    hs = 0;
    for (int i = 0; i < 16; i++) begin
      #1;
      if (bus.host_ready) hs++;
      tick();
    end
    bus.host_valid = 1'b0;
    check("t3_host_beats", 64'(hs), 64'd8);
    check("t3_done", 64'(bus.fill_done), 64'd1);
    check("t3_ena",  64'(bus.fb_ena),    64'd1);
    tick();
    check("t3_busy_off", 64'(bus.fill_busy), 64'd0);

    // T4: fill clipped at the bottom-right corner, then host clipping
    push(130558, 24'h123456);
    push(130559, 24'h123456);
    start_fill(478, 271, 4, 3, 24'h123456);
    tick();
    tick();
    check("t4_done_early", 64'(bus.fill_done), 64'd0);
    tick();
    check("t4_done", 64'(bus.fill_done), 64'd1);
    tick();
    check("t4_busy_off", 64'(bus.fill_busy), 64'd0);

    bus.host_x     = 11'd480;
    bus.host_y     = 11'd0;
    bus.host_color = 24'hABCDEF;
    bus.host_valid = 1'b1;
    #1;
    check("t4_clip_ready", 64'(bus.host_ready), 64'd1);
    tick();
    bus.host_valid = 1'b0;
    check("t4_clip_no_ena", 64'(bus.fb_ena), 64'd0);

    bus.host_x     = 11'd479;
    bus.host_y     = 11'd271;
    bus.host_color = 24'h555555;
    bus.host_valid = 1'b1;
    push(130559, 24'h555555);
    tick();
    bus.host_valid = 1'b0;
    check("t4_corner_ena", 64'(bus.fb_ena), 64'd1);
    tick();

    // T5: empty fill, plus a start request while busy that must be ignored
    start_fill(10, 10, 0, 5, 24'h777777);
    bus.fill_w     = 11'd4;
    bus.fill_h     = 11'd4;
    bus.fill_start = 1'b1;
    tick();
    bus.fill_start = 1'b0;
    check("t5_done", 64'(bus.fill_done), 64'd1);
    check("t5_busy", 64'(bus.fill_busy), 64'd1);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("t5_no_done", 64'(bus.fill_done), 64'd0);
      check("t5_idle",    64'(bus.fill_busy), 64'd0);
    end

    // T6: reset in the middle of a 100x1 fill, then a normal fill
    push(48000, 24'h224466);
    push(48001, 24'h224466);
    push(48002, 24'h224466);
    start_fill(0, 100, 100, 1, 24'h224466);
    tick();
    tick();
    tick();
    tick();
    check("t6_third_ena",  64'(bus.fb_ena),   64'd1);
    check("t6_third_addr", 64'(bus.fb_addra), 64'd48002);
    @(negedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("t6_rst_ena",  64'(bus.fb_ena),    64'd0);
    check("t6_rst_busy", 64'(bus.fill_busy), 64'd0);
    check("t6_rst_done", 64'(bus.fill_done), 64'd0);
    tick();
    tick();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("t6_no_done", 64'(bus.fill_done), 64'd0);
      check("t6_no_ena",  64'(bus.fb_ena),    64'd0);
    end

    push(481, 24'h0F0F0F);
    push(482, 24'h0F0F0F);
    push(483, 24'h0F0F0F);
    start_fill(1, 1, 3, 1, 24'h0F0F0F);
    tick();
    tick();
    tick();
    tick();
    check("t6_new_done", 64'(bus.fill_done), 64'd1);
    tick();
    check("t6_new_idle", 64'(bus.fill_busy), 64'd0);

    tick();
    tick();
    check("sb_empty", 64'(sb.size()), 64'd0);
`ifdef FB_WR_STATS_EN
    check("stat_wr",   64'(stat_wr),   64'd3);
    check("stat_drop", 64'(stat_drop), 64'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
